// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU background line builder.
package ppu_pkg;
    typedef enum logic [2:0] {IDLE, MAP_REQ, LO_REQ, HI_REQ, STORE, PUBLISH} bgState_t;

    localparam logic [12:0] MAP_BASE0        = 13'h1800;
    localparam logic [12:0] MAP_BASE1        = 13'h1C00;
    localparam logic [12:0] TILE_BASE_SIGNED = 13'h1000;

    localparam int LCDC_ENABLE   = 7;
    localparam int LCDC_TILE_SEL = 4;
    localparam int LCDC_MAP_SEL  = 3;

    localparam int SCREEN_W       = 160;
    localparam int TILES_PER_LINE = 21;
endpackage

// File: rtl/ppu_bg_line_builder_if.sv
// VRAM read port between the line builder (master) and VRAM (slave).
interface ppu_bg_line_builder_if;
    logic [12:0] vramAddr;
    logic        vramRd;
    logic [7:0]  vramData;

    modport master (output vramAddr, output vramRd, input vramData);
    modport slave  (input vramAddr, input vramRd, output vramData);
endinterface

// File: rtl/ppu_bg_addr_gen.sv
// Combinational BG address: tile map entry or one byte of a tile row.
module ppu_bg_addr_gen
    import ppu_pkg::*;
(
    input  logic        mapSel,
    input  logic        tileSel,
    input  logic [7:0]  bgY,
    input  logic [4:0]  col,
    input  logic [7:0]  tileT,
    input  logic        hiSel,
    input  logic        isMap,
    output logic [12:0] addr
);
    logic [12:0] mapBase, tileBase, rowOff;

    always_comb begin
        mapBase = mapSel ? MAP_BASE1 : MAP_BASE0;
        // signed mode: sign-extended index*16 around 0x1000, wrapping in 13 bits
        if (tileSel) tileBase = {1'b0, tileT, 4'b0000};
        else         tileBase = TILE_BASE_SIGNED + {tileT[7], tileT, 4'b0000};
        rowOff = {9'd0, bgY[2:0], hiSel};
        addr   = isMap ? (mapBase + {3'd0, bgY[7:3], col}) : (tileBase + rowOff);
    end
endmodule

// File: rtl/ppu_bg_line_builder.sv
// Background scanline builder: walks LY through the frame, fetches BG map/tile data
// for each visible line and publishes two-bitplane line buffers to scanout.
module ppu_bg_line_builder
    import ppu_pkg::*;
#(
    parameter int LINE_CYCLES   = 456,
    parameter int TOTAL_LINES   = 154,
    parameter int VISIBLE_LINES = 144
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic [7:0]            lcdc,
    input  logic [7:0]            scx,
    input  logic [7:0]            scy,
    input  logic [7:0]            bgp,
    ppu_bg_line_builder_if.master vram,
    output logic [7:0]            LY,
    output logic [SCREEN_W-1:0]   LineBuffer0,
    output logic [SCREEN_W-1:0]   LineBuffer1,
    output logic                  updateBufferSignal
);
    localparam int LCW = $clog2(LINE_CYCLES);

    bgState_t            state;
    logic [LCW-1:0]      lineCycle;
    logic [7:0]          scxL, scyL, bgpL, tileT, loByte, bgY;
    logic [4:0]          tileI, col;
    logic [2:0]          fine;
    logic [SCREEN_W-1:0] work0, work1, stMask, stVal0, stVal1;
    logic [12:0]         genAddr;
    logic                fetching, lineEnd, lastLine, lineStart;
    logic [4:0]          unusedLcdc;

    int         xi;
    logic [7:0] xs;
    logic [2:0] bp;
    logic [1:0] raw;

    assign unusedLcdc = {lcdc[6:5], lcdc[2:0]};
    assign bgY        = LY + scyL;
    assign fine       = scxL[2:0];
    assign col        = scxL[7:3] + tileI;
    assign lineEnd    = (lineCycle == LCW'(LINE_CYCLES - 1));
    assign lastLine   = (LY == 8'(TOTAL_LINES - 1));
    assign lineStart  = (lineCycle == '0) && (LY < 8'(VISIBLE_LINES)) && (state == IDLE);

    // read data arrives one cycle after the request, so LO_REQ addresses from live vramData
    assign fetching      = (state == MAP_REQ) || (state == LO_REQ) || (state == HI_REQ);
    assign vram.vramRd   = fetching;
    assign vram.vramAddr = fetching ? genAddr : '0;

    ppu_bg_addr_gen uAddrGen (
        .mapSel (lcdc[LCDC_MAP_SEL]),
        .tileSel(lcdc[LCDC_TILE_SEL]),
        .bgY    (bgY),
        .col    (col),
        .tileT  ((state == LO_REQ) ? vram.vramData : tileT),
        .hiSel  (state == HI_REQ),
        .isMap  (state == MAP_REQ),
        .addr   (genAddr)
    );

    // Expand one tile row (hi on the bus, lo registered) into screen pixels, clipped to 0..159
    always_comb begin
        stMask = '0;
        stVal0 = '0;
        stVal1 = '0;
        xi     = 0;
        xs     = '0;
        bp     = '0;
        raw    = '0;
        for (int p = 0; p < 8; p++) begin
            xi  = 8 * int'(tileI) + p - int'(fine);
            xs  = xi[7:0];
            bp  = 3'(7 - p);
            raw = {vram.vramData[bp], loByte[bp]};
            if (xi >= 0 && xi < SCREEN_W) begin
                stMask[xs] = 1'b1;
                stVal0[xs] = bgpL[{raw, 1'b0}];
                stVal1[xs] = bgpL[{raw, 1'b1}];
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state              <= IDLE;
            lineCycle          <= '0;
            LY                 <= '0;
            scxL               <= '0;
            scyL               <= '0;
            bgpL               <= '0;
            tileI              <= '0;
            tileT              <= '0;
            loByte             <= '0;
            work0              <= '0;
            work1              <= '0;
            LineBuffer0        <= '0;
            LineBuffer1        <= '0;
            updateBufferSignal <= 1'b0;
        end else if (!lcdc[LCDC_ENABLE]) begin
            state              <= IDLE;
            lineCycle          <= '0;
            LY                 <= '0;
            updateBufferSignal <= 1'b0;
        end else begin
            if (lineEnd) begin
                lineCycle          <= '0;
                LY                 <= lastLine ? 8'd0 : LY + 8'd1;
                updateBufferSignal <= 1'b0;
            end else begin
                lineCycle <= lineCycle + LCW'(1);
            end

            unique case (state)
                IDLE: if (lineStart) begin
                    scxL  <= scx;
                    scyL  <= scy;
                    bgpL  <= bgp;
                    work0 <= '0;
                    work1 <= '0;
                    tileI <= '0;
                    state <= MAP_REQ;
                end
                MAP_REQ: state <= LO_REQ;
                LO_REQ: begin
                    tileT <= vram.vramData;
                    state <= HI_REQ;
                end
                HI_REQ: begin
                    loByte <= vram.vramData;
                    state  <= STORE;
                end
                STORE: begin
                    work0 <= (work0 & ~stMask) | stVal0;
                    work1 <= (work1 & ~stMask) | stVal1;
                    tileI <= tileI + 5'd1;
                    state <= (tileI == 5'(TILES_PER_LINE - 1)) ? PUBLISH : MAP_REQ;
                end
                PUBLISH: begin
                    LineBuffer0        <= work0;
                    LineBuffer1        <= work1;
                    updateBufferSignal <= 1'b1;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
